// File: rtl/inst_fetcher.sv
// Instruction fetch controller: fetches at pc, aligns RVC/32-bit encodings and
// holds one instruction for the decoder until issue; redirects on misprediction.
//
// state | meaning
// IDLE  | first cycle after reset, no request yet
// FETCH | request for pc presented to the icache
// WAIT  | request accepted, awaiting icache_valid
// READY | instruction held in front of the decoder
// DROP  | redirected while waiting; swallow the stale response
module inst_fetcher #(
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  output logic        icache_req,
  output logic [31:0] icache_addr,
  input  logic        icache_valid,
  input  logic [31:0] icache_data,
  output logic        start_decode,
  output logic [31:0] inst,
  output logic [31:0] inst_addr,
  input  logic        issue_signal,
  input  logic [31:0] next_pc,
  input  logic        jalr_stall,
  input  logic        wrong_predicted,
  input  logic [31:0] correct_pc
);

  typedef enum logic [2:0] {IDLE, FETCH, WAIT, READY, DROP} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] inst_r;
  logic [31:0] inst_addr_r;
  logic [31:0] aligned;

  // The decoder keeps issue_signal low while stalled on JALR, so the hold needs no extra logic.
  logic unused_jalr_stall;
  assign unused_jalr_stall = jalr_stall;

  assign icache_req   = (state == FETCH) && rdy_in && !wrong_predicted;
  assign icache_addr  = pc;
  assign start_decode = (state == READY);
  assign inst         = inst_r;
  assign inst_addr    = inst_addr_r;

  assign aligned = (icache_data[1:0] == 2'b11) ? icache_data : {16'b0, icache_data[15:0]};

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      inst_r      <= 32'h0;
      inst_addr_r <= 32'h0;
    end else if (rdy_in) begin
      if (wrong_predicted) begin
        pc <= correct_pc;
        case (state)
          WAIT:    state <= icache_valid ? FETCH : DROP;
          DROP:    state <= DROP;
          default: state <= FETCH;
        endcase
      end else begin
        case (state)
          IDLE:  state <= FETCH;
          FETCH: if (icache_req) state <= WAIT;
          WAIT: begin
            if (icache_valid) begin
              inst_r      <= aligned;
              inst_addr_r <= pc;
              state       <= READY;
            end
          end
          READY: begin
            if (issue_signal) begin
              pc    <= next_pc;
              state <= FETCH;
            end
          end
          DROP:    if (icache_valid) state <= FETCH;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
